permutation_sequencer: RTL and testbench

//  Iterative ASCON permutation engine: drives the round index and state into one round datapath
//  (constant addition -> substitution layer -> diffusion layer), one round per clock.

---
 rtl/permutation_sequencer_pkg.sv | 35 +++
 rtl/permutation_sequencer_if.sv | 23 ++
 rtl/constant_addition.sv | 15 +
 rtl/diffusion_layer.sv | 17 +
 rtl/permutation_round.sv | 29 ++
 rtl/substitution_layer.sv | 39 +++
 rtl/permutation_sequencer.sv | 81 ++++++++
 tb/tb_permutation_sequencer.sv | 218 +++++++++++++++++++++
 8 files changed

// File: rtl/permutation_sequencer_pkg.sv
// Shared types and helpers for the iterative ASCON permutation engine.
// Holds the 5x64 state type, round index type, FSM encoding and round-constant math.
package permutation_sequencer_pkg;

  localparam int unsigned LANE_W     = 64;
  localparam int unsigned ROUND_W    = 4;
  localparam int unsigned ROUND_LAST = 11;

  typedef logic [ROUND_W-1:0] round_t;

  typedef struct packed {
    logic [LANE_W-1:0] x0;
    logic [LANE_W-1:0] x1;
    logic [LANE_W-1:0] x2;
    logic [LANE_W-1:0] x3;
    logic [LANE_W-1:0] x4;
  } type_state;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_state_t;

  // Round constant: high nibble is the complement of the round index.
  function automatic logic [2*ROUND_W-1:0] round_constant(input round_t r);
    return {~r, r};
  endfunction

  function automatic logic [LANE_W-1:0] ror64(input logic [LANE_W-1:0] x,
                                              input int unsigned n);
    return (x >> n) | (x << (LANE_W - n));
  endfunction

endpackage

// File: rtl/permutation_sequencer_if.sv
// Request/result bundle between the ASCON mode FSM (master) and the sequencer (slave).
interface permutation_sequencer_if;
  import permutation_sequencer_pkg::*;

  logic      start_i;
  round_t    round_start_i;
  type_state state_i;
  type_state state_o;
  round_t    round_o;
  logic      busy_o;
  logic      done_o;

  modport master (
    output start_i, round_start_i, state_i,
    input  state_o, round_o, busy_o, done_o
  );

  modport slave (
    input  start_i, round_start_i, state_i,
    output state_o, round_o, busy_o, done_o
  );

endinterface

// File: rtl/constant_addition.sv
// Round constant addition: XORs the per-round constant into the low byte of x2.
module constant_addition
  import permutation_sequencer_pkg::*;
(
  input  type_state state_i,
  input  round_t    round_i,
  output type_state state_c
);

  always_comb begin
    state_c    = state_i;
    state_c.x2 = state_i.x2 ^ LANE_W'(round_constant(round_i));
  end

endmodule

// File: rtl/diffusion_layer.sv
// Linear diffusion: each lane XORed with two rotations of itself.
module diffusion_layer
  import permutation_sequencer_pkg::*;
(
  input  type_state state_i,
  output type_state state_c
);

  always_comb begin
    state_c.x0 = state_i.x0 ^ ror64(state_i.x0, 19) ^ ror64(state_i.x0, 28);
    state_c.x1 = state_i.x1 ^ ror64(state_i.x1, 61) ^ ror64(state_i.x1, 39);
    state_c.x2 = state_i.x2 ^ ror64(state_i.x2, 1)  ^ ror64(state_i.x2, 6);
    state_c.x3 = state_i.x3 ^ ror64(state_i.x3, 10) ^ ror64(state_i.x3, 17);
    state_c.x4 = state_i.x4 ^ ror64(state_i.x4, 7)  ^ ror64(state_i.x4, 41);
  end

endmodule

// File: rtl/permutation_round.sv
// One combinational ASCON round: constant addition -> substitution -> diffusion.
module permutation_round
  import permutation_sequencer_pkg::*;
(
  input  type_state state_i,
  input  round_t    round_i,
  output type_state state_c
);

  type_state added_c;
  type_state subst_c;

  constant_addition u_const (
    .state_i (state_i),
    .round_i (round_i),
    .state_c (added_c)
  );

  substitution_layer u_subst (
    .state_i (added_c),
    .state_c (subst_c)
  );

  diffusion_layer u_diff (
    .state_i (subst_c),
    .state_c (state_c)
  );

endmodule

// File: rtl/substitution_layer.sv
// Bit-sliced 5-bit ASCON S-box applied across all 64 lane columns.
module substitution_layer
  import permutation_sequencer_pkg::*;
(
  input  type_state state_i,
  output type_state state_c
);

  logic [LANE_W-1:0] a0, a1, a2, a3, a4;
  logic [LANE_W-1:0] t0, t1, t2, t3, t4;
  logic [LANE_W-1:0] b0, b1, b2, b3, b4;

  always_comb begin
    // Input mixing
    a0 = state_i.x0 ^ state_i.x4;
    a1 = state_i.x1;
    a2 = state_i.x2 ^ state_i.x1;
    a3 = state_i.x3;
    a4 = state_i.x4 ^ state_i.x3;
    // Chi-like nonlinear core
    t0 = ~a0 & a1;
    t1 = ~a1 & a2;
    t2 = ~a2 & a3;
    t3 = ~a3 & a4;
    t4 = ~a4 & a0;
    b0 = a0 ^ t1;
    b1 = a1 ^ t2;
    b2 = a2 ^ t3;
    b3 = a3 ^ t4;
    b4 = a4 ^ t0;
    // Output mixing
    state_c.x0 = b0 ^ b4;
    state_c.x1 = b1 ^ b0;
    state_c.x2 = ~b2;
    state_c.x3 = b3 ^ b2;
    state_c.x4 = b4;
  end

endmodule

// File: rtl/permutation_sequencer.sv
// Iterative ASCON permutation: loads a state on start, applies one round per clock
// from round_start_i through the last round, then pulses done for one cycle.
module permutation_sequencer
  import permutation_sequencer_pkg::*;
(
  input  logic                    clock_i,
  input  logic                    resetb_i,
  permutation_sequencer_if.slave  bus
);

  localparam round_t ROUND_LAST_R = round_t'(ROUND_LAST);

  fsm_state_t fsm_q,   fsm_d;
  type_state  state_q, state_d;
  round_t     round_q, round_d;
  logic       busy_q,  busy_d;
  logic       done_q,  done_d;

  type_state  round_out_c;

  permutation_round u_round (
    .state_i (state_q),
    .round_i (round_q),
    .state_c (round_out_c)
  );

  // Next-state and next-output logic
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    round_d = round_q;
    unique case (fsm_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d = bus.state_i;
          round_d = bus.round_start_i;
          // Start indices past the last round give a zero-round pass.
          fsm_d   = (bus.round_start_i <= ROUND_LAST_R) ? RUN : DONE;
        end
      end
      RUN: begin
        state_d = round_out_c;
        if (round_q == ROUND_LAST_R) begin
          fsm_d = DONE;
        end else begin
          round_d = round_q + round_t'(1);
        end
      end
      DONE: begin
        fsm_d = IDLE;
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
    busy_d = (fsm_d != IDLE);
    done_d = (fsm_d == DONE);
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      round_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      round_q <= round_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.state_o = state_q;
  assign bus.round_o = round_q;
  assign bus.busy_o  = busy_q;
  assign bus.done_o  = done_q;

endmodule

// File: tb/tb_permutation_sequencer.sv
// Scoreboard bench for permutation_sequencer: a driver predicts accepted starts and
// queues reference results; a monitor checks outputs one step after every clock edge.
module tb_permutation_sequencer;
  import permutation_sequencer_pkg::*;

  localparam logic [319:0] GOLD = {64'h80400c0600000000, 64'h0001020304050607,
                                   64'h08090a0b0c0d0e0f, 64'h0011223344556677,
                                   64'h8899aabbccddeeff};

  typedef struct {
    logic [319:0] res;
    int           acc;
    int           rs;
    int           n;
    int           done_cyc;
  } sb_item_t;

  logic clock_i  = 1'b0;
  logic resetb_i = 1'b1;

  permutation_sequencer_if bus ();

  permutation_sequencer dut (
    .clock_i  (clock_i),
    .resetb_i (resetb_i),
    .bus      (bus)
  );

  always #5 clock_i = ~clock_i;

  int           cyc = 0;
  int           idle_from = 0;
  int           last_acc = 0;
  bit           in_reset = 1'b1;
  logic [319:0] last_result = '0;
  sb_item_t     sb[$];
  int           n_cmp = 0;
  int           n_err = 0;

  always @(posedge clock_i) cyc <= cyc + 1;

  function automatic logic [63:0] rot(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Reference permutation, written the way the ASCON C model reads.
  function automatic logic [319:0] ref_perm(input logic [319:0] s, input int rs);
    logic [63:0] x[5];
    logic [63:0] t[5];
    for (int i = 0; i < 5; i++) x[i] = s[319-64*i -: 64];
    for (int r = rs; r <= 11; r++) begin
      x[2] ^= 64'((15 - r) * 16 + r);
      x[0] ^= x[4]; x[4] ^= x[3]; x[2] ^= x[1];
      for (int i = 0; i < 5; i++) t[i] = ~x[i] & x[(i + 1) % 5];
      for (int i = 0; i < 5; i++) x[i] ^= t[(i + 1) % 5];
      x[1] ^= x[0]; x[0] ^= x[4]; x[3] ^= x[2]; x[2] = ~x[2];
      x[0] ^= rot(x[0], 19) ^ rot(x[0], 28);
      x[1] ^= rot(x[1], 61) ^ rot(x[1], 39);
      x[2] ^= rot(x[2], 1)  ^ rot(x[2], 6);
      x[3] ^= rot(x[3], 10) ^ rot(x[3], 17);
      x[4] ^= rot(x[4], 7)  ^ rot(x[4], 41);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [319:0] rand320();
    logic [319:0] v;
    for (int i = 0; i < 10; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [3:0] pick_rs();
    case ($urandom_range(0, 4))
      0:       return 4'd0;
      1:       return 4'd6;
      2:       return 4'd11;
      3:       return 4'd13;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  // Drive one cycle of inputs; predict whether the coming edge accepts a start.
  task automatic step(input bit st, input logic [319:0] s, input logic [3:0] rs);
    sb_item_t it;
    int       edge_n;
    @(negedge clock_i);
    bus.start_i       = st;
    bus.state_i       = type_state'(s);
    bus.round_start_i = rs;
    edge_n = cyc + 1;
    if (st && !in_reset && edge_n >= idle_from) begin
      it.rs       = int'(rs);
      it.n        = (it.rs <= 11) ? 12 - it.rs : 0;
      it.res      = ref_perm(s, it.rs);
      it.acc      = edge_n;
      it.done_cyc = edge_n + it.n;
      sb.push_back(it);
      idle_from   = edge_n + it.n + 2;
      last_acc    = edge_n;
    end
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (cyc + 1 < idle_from && guard < 40) begin
      step(1'b0, rand320(), pick_rs());
      guard++;
    end
    if (cyc + 1 < idle_from) chk("idle_timeout", 320'(cyc), 320'(idle_from));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},  320'(bus.busy_o),  320'(0));
    chk({tag, "_done"},  320'(bus.done_o),  320'(0));
    chk({tag, "_round"}, 320'(bus.round_o), 320'(0));
    chk({tag, "_state"}, 320'(bus.state_o), 320'(0));
  endtask

  task automatic apply_reset(input string tag);
    in_reset = 1'b1;
    resetb_i = 1'b0;
    #1;
    check_reset_outputs(tag);
    sb.delete();
    idle_from   = 0;
    last_result = '0;
    repeat (2) @(negedge clock_i);
    resetb_i = 1'b1;
    in_reset = 1'b0;
  endtask

  // Monitor: compares against the model just after every active edge.
  always @(posedge clock_i) begin
    bit busy_exp;
    bit done_exp;
    int j;
    int rexp;
    #1;
    if (in_reset) begin
      check_reset_outputs("in_reset");
    end else begin
      busy_exp = (cyc + 2 <= idle_from);
      done_exp = (sb.size() > 0) && (sb[0].done_cyc == cyc);
      chk("busy", 320'(bus.busy_o), 320'(busy_exp));
      chk("done", 320'(bus.done_o), 320'(done_exp));
      if (busy_exp && sb.size() > 0) begin
        j = cyc - sb[0].acc;
        if (sb[0].n == 0)     rexp = sb[0].rs;
        else if (j < sb[0].n) rexp = sb[0].rs + j;
        else                  rexp = 11;
        chk("round", 320'(bus.round_o), 320'(rexp));
      end
      if (done_exp) begin
        chk("result", 320'(bus.state_o), sb[0].res);
        last_result = sb[0].res;
        void'(sb.pop_front());
      end else if (!busy_exp) begin
        chk("hold", 320'(bus.state_o), last_result);
      end
    end
  end

  initial begin
    bus.start_i       = 1'b0;
    bus.round_start_i = '0;
    bus.state_i       = '0;
    #3;
    apply_reset("por");

    // Fixed-vector runs: p12, p6, single round, zero-round
    step(1'b1, GOLD, 4'd0);  wait_idle();
    step(1'b1, GOLD, 4'd6);  wait_idle();
    step(1'b1, GOLD, 4'd11); wait_idle();
    step(1'b1, GOLD, 4'd13); wait_idle();

    // start held high across back-to-back runs
    for (int i = 0; i < 80; i++)
      step(1'b1, rand320(), (i < 40) ? ((i % 3 == 0) ? 4'd13 : 4'd0) : pick_rs());
    wait_idle();

    // Sparse random starts
    repeat (150) step($urandom_range(0, 2) == 0, rand320(), pick_rs());
    wait_idle();

    // Reset in the middle of a p12 run at round 5, then rerun
    step(1'b1, GOLD, 4'd0);
    repeat (5) step(1'b0, rand320(), pick_rs());
    @(negedge clock_i);
    chk("mid_round", 320'(bus.round_o), 320'(5));
    chk("mid_cyc", 320'(cyc), 320'(last_acc + 5));
    apply_reset("mid");
    step(1'b1, GOLD, 4'd0);
    wait_idle();

    repeat (100) step($urandom_range(0, 1) == 0, rand320(), pick_rs());
    wait_idle();
    repeat (3) step(1'b0, rand320(), pick_rs());
    chk("sb_drained", 320'(sb.size()), 320'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #90000;
    $display("FAIL watchdog: simulation did not complete, cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
